// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a per-register scoreboard
// (pending bit + producer tag) for the register-read stage.
//  - Issue allocates destinations (pending <= 1, tag recorded).
//  - Writeback retires them; a writeback whose tag no longer matches a pending
//    register is stale and is dropped, which keeps WAW ordering without extra logic.
//  - Reads are combinational and return operand data plus a ready flag.
// Register 0 is hardwired to zero and always ready.
// Optional feature macro: REGFILE_SB_BYPASS_EN
//  defined   : same-cycle writeback-to-read forwarding on the read ports.
//  undefined : reads see only the pre-edge register state.
// The macro touches only the read-side combinational outputs, never state updates.
module regfile_sb #(
   parameter int s_index         = 5,
   parameter int s_width         = 32,
   parameter int s_tag           = 4,
   parameter int num_read_ports  = 4,
   parameter int num_write_ports = 2,
   parameter int num_alloc_ports = 2
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic [num_alloc_ports-1:0]                     alloc,
   input  logic [num_alloc_ports-1:0][s_index-1:0]        alloc_dest,
   input  logic [num_alloc_ports-1:0][s_tag-1:0]          alloc_tag,
   input  logic [num_write_ports-1:0]                     ld,
   input  logic [num_write_ports-1:0][s_index-1:0]        dest,
   input  logic [num_write_ports-1:0][s_tag-1:0]          wtag,
   input  logic [num_write_ports-1:0][s_width-1:0]        in,
   input  logic [num_read_ports-1:0][s_index-1:0]         src,
   output logic [num_read_ports-1:0][s_width-1:0]         out,
   output logic [num_read_ports-1:0]                      rdy
);

   localparam int num_regs = 2 ** s_index;

   // Architectural state per register
   logic [s_width-1:0] r_data [num_regs];
   logic [num_regs-1:0] r_pend;
   logic [s_tag-1:0]   r_tag  [num_regs];

   // Per-port writeback hit and per-register resolved write / allocate requests
   logic [num_write_ports-1:0] w_hit;
   logic [num_regs-1:0]        w_wr_en;
   logic [s_width-1:0]         w_wr_data [num_regs];
   logic [num_regs-1:0]        w_al_en;
   logic [s_tag-1:0]           w_al_tag  [num_regs];

   // Resolve writeback hits against pre-edge scoreboard state; later ports override earlier ones
   always_comb begin
      w_hit   = '0;
      w_wr_en = '0;
      for (int r = 0; r < num_regs; r++) begin
         w_wr_data[r] = '0;
      end
      for (int i = 0; i < num_write_ports; i++) begin
         w_hit[i] = ld[i] && (dest[i] != '0) &&
                    (!r_pend[dest[i]] || (r_tag[dest[i]] == wtag[i]));
         if (w_hit[i]) begin
            w_wr_en[dest[i]]   = 1'b1;
            w_wr_data[dest[i]] = in[i];
         end
      end
   end

   // Resolve allocations per register; later ports override the recorded tag
   always_comb begin
      w_al_en = '0;
      for (int r = 0; r < num_regs; r++) begin
         w_al_tag[r] = '0;
      end
      for (int j = 0; j < num_alloc_ports; j++) begin
         if (alloc[j] && (alloc_dest[j] != '0)) begin
            w_al_en[alloc_dest[j]]  = 1'b1;
            w_al_tag[alloc_dest[j]] = alloc_tag[j];
         end
      end
   end

   // State update: data from hitting writebacks; allocation takes priority over retirement for pending/tag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend <= '0;
         for (int r = 0; r < num_regs; r++) begin
            r_data[r] <= '0;
            r_tag[r]  <= '0;
         end
      end else begin
         for (int r = 1; r < num_regs; r++) begin
            if (w_wr_en[r]) begin
               r_data[r] <= w_wr_data[r];
            end
            if (w_al_en[r]) begin
               r_pend[r] <= 1'b1;
               r_tag[r]  <= w_al_tag[r];
            end else if (w_wr_en[r]) begin
               r_pend[r] <= 1'b0;
            end
         end
      end
   end

   // Read ports: zero-latency operand data and ready flag, forced to zero while in reset
   always_comb begin
      for (int k = 0; k < num_read_ports; k++) begin
         out[k] = '0;
         rdy[k] = 1'b0;
         if (rst_n) begin
            if (src[k] == '0) begin
               out[k] = '0;
               rdy[k] = 1'b1;
            end else begin
`ifdef REGFILE_SB_BYPASS_EN
               if (w_wr_en[src[k]]) begin
                  out[k] = w_wr_data[src[k]];
                  rdy[k] = 1'b1;
               end else begin
                  out[k] = r_data[src[k]];
                  rdy[k] = !r_pend[src[k]];
               end
`else
               out[k] = r_data[src[k]];
               rdy[k] = !r_pend[src[k]];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed, table-driven bench for regfile_sb (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
module tb_regfile_sb;

   logic                 clk;
   logic                 rst_n;
   logic [1:0]           t_alloc;
   logic [1:0][4:0]      t_alloc_dest;
   logic [1:0][3:0]      t_alloc_tag;
   logic [1:0]           t_ld;
   logic [1:0][4:0]      t_dest;
   logic [1:0][3:0]      t_wtag;
   logic [1:0][31:0]     t_in;
   logic [3:0][4:0]      t_src;
   logic [3:0][31:0]     t_out;
   logic [3:0]           t_rdy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]       al;
      logic [1:0][4:0]  ad;
      logic [1:0][3:0]  at;
      logic [1:0]       ld;
      logic [1:0][4:0]  wd;
      logic [1:0][3:0]  wt;
      logic [1:0][31:0] wdat;
      logic [3:0][4:0]  src;
      logic [3:0][31:0] eout;
      logic [3:0]       erdy;
   } vec_t;

   vec_t vt [21];

   regfile_sb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (t_alloc),
      .alloc_dest (t_alloc_dest),
      .alloc_tag  (t_alloc_tag),
      .ld         (t_ld),
      .dest       (t_dest),
      .wtag       (t_wtag),
      .in         (t_in),
      .src        (t_src),
      .out        (t_out),
      .rdy        (t_rdy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic [1:0] al, input logic [9:0] ad, input logic [7:0] at,
                               input logic [1:0] ld, input logic [9:0] wd, input logic [7:0] wt,
                               input logic [63:0] wdat, input logic [19:0] src,
                               input logic [127:0] eout, input logic [3:0] erdy);
      vec_t v;
      v.al = al; v.ad = ad; v.at = at;
      v.ld = ld; v.wd = wd; v.wt = wt; v.wdat = wdat;
      v.src = src; v.eout = eout; v.erdy = erdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      t_alloc = '0; t_alloc_dest = '0; t_alloc_tag = '0;
      t_ld = '0; t_dest = '0; t_wtag = '0; t_in = '0;
   endtask

   task automatic chk_port(input string name, input int k, input logic [31:0] eo, input logic er);
      chk($sformatf("%s out[%0d] src=%0d", name, k, t_src[k]), t_out[k], eo);
      chk($sformatf("%s rdy[%0d] src=%0d", name, k, t_src[k]), {31'd0, t_rdy[k]}, {31'd0, er});
   endtask

   initial begin
      idle();
      t_src = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Test 1: random fills, then one reset edge
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            t_ld[p]         = 1'b1;
            t_dest[p]       = 5'($urandom_range(31, 1));
            t_wtag[p]       = 4'($urandom_range(15, 0));
            t_in[p]         = $urandom;
            t_alloc[p]      = 1'($urandom_range(1, 0));
            t_alloc_dest[p] = 5'($urandom_range(31, 1));
            t_alloc_tag[p]  = 4'($urandom_range(15, 0));
         end
      end
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      t_src = {5'd31, 5'd17, 5'd3, 5'd0};
      #1;
      for (int k = 0; k < 4; k++) chk_port("in_reset", k, 32'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < 8; g++) begin
         if (g != 0) @(negedge clk);
         for (int k = 0; k < 4; k++) t_src[k] = 5'(4 * g + k);
         #1;
         for (int k = 0; k < 4; k++) chk_port("after_reset", k, 32'd0, 1'b1);
      end

      // Tests 2-5 plus double-alloc tag priority, as a cycle-by-cycle table
      vt[0]  = mk(2'b01, {5'd0,5'd5}, {4'd0,4'd3}, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd0,5'd5}, 128'd0, 4'b1111);
      vt[1]  = mk(2'b00, 10'd0, 8'd0, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd0,5'd5}, 128'd0, 4'b1110);
      vt[2]  = mk(2'b00, 10'd0, 8'd0, 2'b01, {5'd0,5'd5}, {4'd0,4'd3}, {32'd0,32'hDEADBEEF},
                  {5'd3,5'd2,5'd1,5'd0}, 128'd0, 4'b1111);
      vt[3]  = mk(2'b01, {5'd0,5'd7}, {4'd0,4'd1}, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd0,5'd5}, {32'd0,32'd0,32'd0,32'hDEADBEEF}, 4'b1111);
      vt[4]  = mk(2'b10, {5'd7,5'd0}, {4'd2,4'd0}, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd0,5'd5}, {32'd0,32'd0,32'd0,32'hDEADBEEF}, 4'b1011);
      vt[5]  = mk(2'b00, 10'd0, 8'd0, 2'b01, {5'd0,5'd7}, {4'd0,4'd1}, {32'd0,32'h11},
                  {5'd9,5'd7,5'd0,5'd5}, {32'd0,32'd0,32'd0,32'hDEADBEEF}, 4'b1011);
      vt[6]  = mk(2'b00, 10'd0, 8'd0, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd0,5'd5}, {32'd0,32'd0,32'd0,32'hDEADBEEF}, 4'b1011);
      vt[7]  = mk(2'b00, 10'd0, 8'd0, 2'b10, {5'd7,5'd0}, {4'd2,4'd0}, {32'h22,32'd0},
                  {5'd9,5'd5,5'd0,5'd1}, {32'd0,32'hDEADBEEF,32'd0,32'd0}, 4'b1111);
      vt[8]  = mk(2'b00, 10'd0, 8'd0, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd0,5'd5}, {32'd0,32'h22,32'd0,32'hDEADBEEF}, 4'b1111);
      vt[9]  = mk(2'b00, 10'd0, 8'd0, 2'b11, {5'd9,5'd9}, {4'd5,4'd0}, {32'h5555,32'hAAAA},
                  {5'd7,5'd5,5'd0,5'd1}, {32'h22,32'hDEADBEEF,32'd0,32'd0}, 4'b1111);
      vt[10] = mk(2'b00, 10'd0, 8'd0, 2'b01, {5'd0,5'd0}, {4'd0,4'd0}, {32'd0,32'hFFFF},
                  {5'd7,5'd5,5'd0,5'd9}, {32'h22,32'hDEADBEEF,32'd0,32'h5555}, 4'b1111);
      vt[11] = mk(2'b01, {5'd0,5'd4}, {4'd0,4'd2}, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd4,5'd9,5'd0,5'd0}, {32'd0,32'h5555,32'd0,32'd0}, 4'b1111);
      vt[12] = mk(2'b10, {5'd4,5'd0}, {4'd6,4'd0}, 2'b01, {5'd0,5'd4}, {4'd0,4'd2}, {32'd0,32'h44},
                  {5'd9,5'd7,5'd5,5'd0}, {32'h5555,32'h22,32'hDEADBEEF,32'd0}, 4'b1111);
      vt[13] = mk(2'b00, 10'd0, 8'd0, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd5,5'd4}, {32'h5555,32'h22,32'hDEADBEEF,32'h44}, 4'b1110);
      vt[14] = mk(2'b00, 10'd0, 8'd0, 2'b10, {5'd4,5'd0}, {4'd2,4'd0}, {32'h99,32'd0},
                  {5'd9,5'd7,5'd5,5'd0}, {32'h5555,32'h22,32'hDEADBEEF,32'd0}, 4'b1111);
      vt[15] = mk(2'b00, 10'd0, 8'd0, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd5,5'd4}, {32'h5555,32'h22,32'hDEADBEEF,32'h44}, 4'b1110);
      vt[16] = mk(2'b00, 10'd0, 8'd0, 2'b01, {5'd0,5'd4}, {4'd0,4'd6}, {32'd0,32'h66},
                  {5'd9,5'd7,5'd5,5'd0}, {32'h5555,32'h22,32'hDEADBEEF,32'd0}, 4'b1111);
      vt[17] = mk(2'b11, {5'd10,5'd10}, {4'd9,4'd1}, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd9,5'd7,5'd5,5'd4}, {32'h5555,32'h22,32'hDEADBEEF,32'h66}, 4'b1111);
      vt[18] = mk(2'b00, 10'd0, 8'd0, 2'b01, {5'd0,5'd10}, {4'd0,4'd1}, {32'd0,32'hA1},
                  {5'd0,5'd0,5'd0,5'd10}, 128'd0, 4'b1110);
      vt[19] = mk(2'b00, 10'd0, 8'd0, 2'b10, {5'd10,5'd0}, {4'd9,4'd0}, {32'hA9,32'd0},
                  {5'd0,5'd0,5'd0,5'd1}, 128'd0, 4'b1111);
      vt[20] = mk(2'b00, 10'd0, 8'd0, 2'b00, 10'd0, 8'd0, 64'd0,
                  {5'd0,5'd0,5'd0,5'd10}, {32'd0,32'd0,32'd0,32'hA9}, 4'b1111);

      for (int v = 0; v < 21; v++) begin
         @(negedge clk);
         t_alloc = vt[v].al; t_alloc_dest = vt[v].ad; t_alloc_tag = vt[v].at;
         t_ld = vt[v].ld; t_dest = vt[v].wd; t_wtag = vt[v].wt; t_in = vt[v].wdat;
         t_src = vt[v].src;
         #1;
         for (int k = 0; k < 4; k++)
            chk_port($sformatf("vec%0d", v), k, vt[v].eout[k], vt[v].erdy[k]);
      end

      // Test 6: same-cycle writeback and read of r3 (not pending)
      @(negedge clk);
      idle();
      t_ld[0] = 1'b1; t_dest[0] = 5'd3; t_wtag[0] = 4'd0; t_in[0] = 32'h33;
      t_src = {5'd0, 5'd0, 5'd0, 5'd3};
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk_port("fwd_r3", 0, 32'h33, 1'b1);
`else
      chk_port("fwd_r3", 0, 32'h0, 1'b1);
`endif
      @(negedge clk);
      idle();
      #1;
      chk_port("r3_next", 0, 32'h33, 1'b1);

      // Forwarding onto a pending register, then dual-port hit on one register
      @(negedge clk);
      t_alloc[0] = 1'b1; t_alloc_dest[0] = 5'd12; t_alloc_tag[0] = 4'd5;
      @(negedge clk);
      idle();
      t_ld[1] = 1'b1; t_dest[1] = 5'd12; t_wtag[1] = 4'd5; t_in[1] = 32'h12;
      t_src = {5'd0, 5'd0, 5'd0, 5'd12};
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk_port("fwd_r12", 0, 32'h12, 1'b1);
`else
      chk_port("fwd_r12", 0, 32'h0, 1'b0);
`endif
      @(negedge clk);
      idle();
      t_ld = 2'b11; t_dest = {5'd13, 5'd13}; t_in = {32'h2, 32'h1};
      t_src = {5'd0, 5'd0, 5'd13, 5'd12};
      #1;
      chk_port("r12_next", 0, 32'h12, 1'b1);
`ifdef REGFILE_SB_BYPASS_EN
      chk_port("fwd_r13", 1, 32'h2, 1'b1);
`else
      chk_port("fwd_r13", 1, 32'h0, 1'b1);
`endif
      @(negedge clk);
      idle();
      #1;
      chk_port("r13_next", 1, 32'h2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
